// File: rtl/robot_multi_sensor.sv
// robot_multi_sensor
//   Multi-channel obstacle/alarm controller. Each distance channel is
//   registered, classified with a near/far hysteresis window and
//   debounced. A registered SAFE/WARN/ALARM/HOLD state machine consumes
//   the debounced detect bits and drives the warning/alarm outputs.
//
// Ports:
//   clk              - system clock, rising edge
//   rst              - asynchronous reset, active-high
//   dist_v           - packed distances, channel i at [i*DATA_IN_WIDTH +: DATA_IN_WIDTH]
//   alarm_ack        - alarm acknowledge (only with ROBOT_ALARM_ACK_EN)
//   obs_detected_out - registered per-channel debounced detect bits
//   obs_count        - popcount of obs_detected_out
//   warn_flag        - registered, high while in WARN
//   alarm_flag       - registered, high while in ALARM or HOLD
//   state_out        - SAFE=0, WARN=1, ALARM=2, HOLD=3
//
// Build option:
//   ROBOT_ALARM_ACK_EN - once the HOLD countdown expires, stay latched in
//   HOLD until alarm_ack is seen with no channel detected.
module robot_multi_sensor #(
  parameter int unsigned NUM_SENSORS   = 4,
  parameter int unsigned DATA_IN_WIDTH = 16,
  parameter int unsigned MIN_DIST      = 50,
  parameter int unsigned CLEAR_DIST    = 60,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned ALARM_COUNT   = 2,
  parameter int unsigned WARN_CYCLES   = 8,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SENSORS*DATA_IN_WIDTH-1:0]   dist_v,
`ifdef ROBOT_ALARM_ACK_EN
  input  logic                                   alarm_ack,
`endif
  output logic [NUM_SENSORS-1:0]                 obs_detected_out,
  output logic [$clog2(NUM_SENSORS+1)-1:0]       obs_count,
  output logic                                   warn_flag,
  output logic                                   alarm_flag,
  output logic [1:0]                             state_out
);

  localparam int unsigned TMAX = (WARN_CYCLES > HOLD_CYCLES) ? WARN_CYCLES : HOLD_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned DW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned CW   = $clog2(NUM_SENSORS + 1);

  // One extra bit so thresholds equal to 2**DATA_IN_WIDTH still compare correctly.
  localparam logic [DATA_IN_WIDTH:0] MIN_L   = (DATA_IN_WIDTH+1)'(MIN_DIST);
  localparam logic [DATA_IN_WIDTH:0] CLEAR_L = (DATA_IN_WIDTH+1)'(CLEAR_DIST);

  typedef enum logic [1:0] {
    S_SAFE  = 2'd0,
    S_WARN  = 2'd1,
    S_ALARM = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  logic [NUM_SENSORS*DATA_IN_WIDTH-1:0] r_dist_q;
  logic [DW-1:0]                        r_cnt [NUM_SENSORS];
  logic [NUM_SENSORS-1:0]               r_obs;
  logic [TW-1:0]                        r_timer;
  state_t                               r_state;
  logic                                 r_warn;
  logic                                 r_alarm;

  logic [NUM_SENSORS-1:0]               w_qual;
  logic [DATA_IN_WIDTH:0]               w_ch;
  logic [CW-1:0]                        w_count;
  state_t                               w_state_nx;
  logic [TW-1:0]                        w_timer_nx;

  // Qualifying condition depends on the current detect bit: look for
  // "near" while clear and "far" while detected; the band between is neither.
  always_comb begin
    w_qual = '0;
    w_ch   = '0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      w_ch      = {1'b0, r_dist_q[i*DATA_IN_WIDTH +: DATA_IN_WIDTH]};
      w_qual[i] = r_obs[i] ? (w_ch >= CLEAR_L) : (w_ch < MIN_L);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dist_q <= '0;
      r_obs    <= '0;
      for (int unsigned i = 0; i < NUM_SENSORS; i++) r_cnt[i] <= '0;
    end else begin
      r_dist_q <= dist_v;
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        if (w_qual[i]) begin
          if (r_cnt[i] == DW'(DEBOUNCE - 1)) begin
            r_obs[i] <= ~r_obs[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) w_count += CW'(r_obs[i]);
  end

  // Timer counts down the remaining cycles of WARN/HOLD; a value of 1
  // means this is the last cycle in the state.
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    case (r_state)
      S_SAFE: begin
        if (32'(w_count) >= ALARM_COUNT) begin
          w_state_nx = S_ALARM;
          w_timer_nx = '0;
        end else if (w_count != '0) begin
          w_state_nx = S_WARN;
          w_timer_nx = TW'(WARN_CYCLES);
        end
      end
      S_WARN: begin
        if (w_count == '0) begin
          w_state_nx = S_SAFE;
          w_timer_nx = '0;
        end else if (32'(w_count) >= ALARM_COUNT || r_timer <= TW'(1)) begin
          w_state_nx = S_ALARM;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer - 1'b1;
        end
      end
      S_ALARM: begin
        if (w_count == '0) begin
          w_state_nx = S_HOLD;
          w_timer_nx = TW'(HOLD_CYCLES);
        end
      end
      S_HOLD: begin
        if (w_count != '0) begin
          w_state_nx = S_ALARM;
          w_timer_nx = '0;
        end else if (r_timer > TW'(1)) begin
          w_timer_nx = r_timer - 1'b1;
        end else begin
`ifdef ROBOT_ALARM_ACK_EN
          // Expired countdown parks at timer=0; release only on ack.
          w_timer_nx = '0;
          if (r_timer == '0 && alarm_ack) w_state_nx = S_SAFE;
`else
          w_state_nx = S_SAFE;
          w_timer_nx = '0;
`endif
        end
      end
      default: begin
        w_state_nx = S_SAFE;
        w_timer_nx = '0;
      end
    endcase
  end

  // Flags are registered from the next state so they align with state_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_SAFE;
      r_timer <= '0;
      r_warn  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_warn  <= (w_state_nx == S_WARN);
      r_alarm <= (w_state_nx == S_ALARM) || (w_state_nx == S_HOLD);
    end
  end

  assign obs_detected_out = r_obs;
  assign obs_count        = w_count;
  assign warn_flag        = r_warn;
  assign alarm_flag       = r_alarm;
  assign state_out        = r_state;

endmodule

// File: tb/tb_robot_multi_sensor.sv
// Testbench for robot_multi_sensor (default build, no acknowledge port use).
module tb_robot_multi_sensor;

  localparam logic [1:0] ST_S = 2'd0;
  localparam logic [1:0] ST_W = 2'd1;
  localparam logic [1:0] ST_A = 2'd2;
  localparam logic [1:0] ST_H = 2'd3;
  localparam logic [15:0] F   = 16'd1000;

  logic        clk;
  logic        rst;
  logic [63:0] dist_v;
  logic        r_ack;
  logic [3:0]  obs_detected_out;
  logic [2:0]  obs_count;
  logic        warn_flag;
  logic        alarm_flag;
  logic [1:0]  state_out;

  robot_multi_sensor #(
    .NUM_SENSORS(4), .DATA_IN_WIDTH(16), .MIN_DIST(50), .CLEAR_DIST(60),
    .DEBOUNCE(3), .ALARM_COUNT(2), .WARN_CYCLES(8), .HOLD_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dist_v(dist_v),
`ifdef ROBOT_ALARM_ACK_EN
    .alarm_ack(r_ack),
`endif
    .obs_detected_out(obs_detected_out),
    .obs_count(obs_count),
    .warn_flag(warn_flag),
    .alarm_flag(alarm_flag),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int unsigned ncyc;
    logic [3:0]  obs;
    logic [1:0]  st;
    bit          rf;
  } rec_t;

  typedef struct packed {
    logic [3:0] obs;
    logic [1:0] st;
  } exp_t;

  rec_t tbl[$];
  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  task automatic add(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                     input logic [15:0] c3, input int unsigned cyc, input logic [3:0] o,
                     input logic [1:0] s, input bit rfirst);
    rec_t r;
    r.d = {c3, c2, c1, c0};
    r.ncyc = cyc;
    r.obs = o;
    r.st = s;
    r.rf = rfirst;
    tbl.push_back(r);
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, req);
    end
  endtask

  function automatic logic [2:0] popc(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_obs"},   32'(obs_detected_out), 32'(e.obs));
      chk({tag, "_cnt"},   32'(obs_count),        32'(popc(e.obs)));
      chk({tag, "_state"}, 32'(state_out),        32'(e.st));
      chk({tag, "_warn"},  32'(warn_flag),        32'(e.st == ST_W));
      chk({tag, "_alarm"}, 32'(alarm_flag),       32'(e.st == ST_A || e.st == ST_H));
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input int idx);
    rst = 1'b1;
    sb.push_back('{obs: 4'b0000, st: ST_S});
    #1;
    check_out($sformatf("rst%0d", idx));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    r_ack    = 1'b0;
    dist_v   = {F, F, F, F};

    // Reset, idle
    add(F, F, F, F, 20, 4'b0000, ST_S, 1);
    // Single channel: detect, WARN, WARN timeout -> ALARM, clear, HOLD 16, SAFE
    add(16'd30, F, F, F, 3, 4'b0000, ST_S, 0);
    add(16'd30, F, F, F, 1, 4'b0001, ST_S, 0);
    add(16'd30, F, F, F, 1, 4'b0001, ST_W, 0);
    add(16'd30, F, F, F, 7, 4'b0001, ST_W, 0);
    add(16'd30, F, F, F, 1, 4'b0001, ST_A, 0);
    add(F, F, F, F, 3, 4'b0001, ST_A, 0);
    add(F, F, F, F, 1, 4'b0000, ST_A, 0);
    add(F, F, F, F, 1, 4'b0000, ST_H, 0);
    add(F, F, F, F, 15, 4'b0000, ST_H, 0);
    add(F, F, F, F, 1, 4'b0000, ST_S, 0);
    // Chatter on channel 1 never qualifies
    for (int k = 0; k < 4; k++) begin
      add(F, 16'd30, F, F, 2, 4'b0000, ST_S, 0);
      add(F, F, F, F, 2, 4'b0000, ST_S, 0);
    end
    // Detect ch1, dwell in hysteresis band, then clear from WARN straight to SAFE
    add(F, 16'd30, F, F, 3, 4'b0000, ST_S, 0);
    add(F, 16'd30, F, F, 1, 4'b0010, ST_S, 0);
    add(F, 16'd30, F, F, 1, 4'b0010, ST_W, 0);
    add(F, 16'd55, F, F, 3, 4'b0010, ST_W, 0);
    add(F, F, F, F, 3, 4'b0010, ST_W, 0);
    add(F, F, F, F, 1, 4'b0000, ST_W, 0);
    add(F, F, F, F, 1, 4'b0000, ST_S, 0);
    // Threshold boundaries: 50 not near, 49 near, 59 not far, 60 far
    add(F, F, 16'd50, F, 5, 4'b0000, ST_S, 0);
    add(F, F, 16'd49, F, 3, 4'b0000, ST_S, 0);
    add(F, F, 16'd49, F, 1, 4'b0100, ST_S, 0);
    add(F, F, 16'd59, F, 1, 4'b0100, ST_W, 0);
    add(F, F, 16'd59, F, 2, 4'b0100, ST_W, 0);
    add(F, F, 16'd60, F, 3, 4'b0100, ST_W, 0);
    add(F, F, 16'd60, F, 1, 4'b0000, ST_W, 0);
    add(F, F, 16'd60, F, 1, 4'b0000, ST_S, 0);
    // Extremes 0 / all-ones, then a second channel escalates WARN -> ALARM early
    add(16'hFFFF, F, F, 16'd0, 3, 4'b0000, ST_S, 0);
    add(16'hFFFF, F, F, 16'd0, 1, 4'b1000, ST_S, 0);
    add(16'hFFFF, F, F, 16'd0, 1, 4'b1000, ST_W, 0);
    add(16'hFFFF, 16'd0, F, 16'd0, 3, 4'b1000, ST_W, 0);
    add(16'hFFFF, 16'd0, F, 16'd0, 1, 4'b1010, ST_W, 0);
    add(16'hFFFF, 16'd0, F, 16'd0, 1, 4'b1010, ST_A, 0);
    // Reset from ALARM; dist_q=0 after reset must not create a detection
    add(F, F, F, F, 3, 4'b0000, ST_S, 1);
    // Two channels at once: SAFE -> ALARM directly
    add(16'd10, F, 16'd10, F, 3, 4'b0000, ST_S, 0);
    add(16'd10, F, 16'd10, F, 1, 4'b0101, ST_S, 0);
    add(16'd10, F, 16'd10, F, 1, 4'b0101, ST_A, 0);
    // Clear, re-detect during HOLD, then full HOLD length again
    add(F, F, F, F, 3, 4'b0101, ST_A, 0);
    add(F, F, F, F, 1, 4'b0000, ST_A, 0);
    add(F, F, F, F, 1, 4'b0000, ST_H, 0);
    add(F, F, F, F, 4, 4'b0000, ST_H, 0);
    add(F, F, F, 16'd20, 3, 4'b0000, ST_H, 0);
    add(F, F, F, 16'd20, 1, 4'b1000, ST_H, 0);
    add(F, F, F, 16'd20, 1, 4'b1000, ST_A, 0);
    add(F, F, F, F, 3, 4'b1000, ST_A, 0);
    add(F, F, F, F, 1, 4'b0000, ST_A, 0);
    add(F, F, F, F, 1, 4'b0000, ST_H, 0);
    add(F, F, F, F, 15, 4'b0000, ST_H, 0);
    add(F, F, F, F, 1, 4'b0000, ST_S, 0);
    // Reset asserted mid-ALARM
    add(16'd5, 16'd5, F, F, 3, 4'b0000, ST_S, 0);
    add(16'd5, 16'd5, F, F, 1, 4'b0011, ST_S, 0);
    add(16'd5, 16'd5, F, F, 1, 4'b0011, ST_A, 0);
    add(F, F, F, F, 4, 4'b0000, ST_S, 1);

    #3;
    for (int i = 0; i < tbl.size(); i++) begin
      dist_v = tbl[i].d;
      if (tbl[i].rf) do_reset(i);
      sb.push_back('{obs: tbl[i].obs, st: tbl[i].st});
      repeat (tbl[i].ncyc) @(posedge clk);
      #1;
      check_out($sformatf("rec%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/robot_multi_sensor.md
Name: robot_multi_sensor

Overview:
Next-generation obstacle/alarm controller for the robot datapath. Monitors NUM_SENSORS distance channels. Each channel gets a hysteresis threshold and a debounce filter. A registered SAFE/WARN/ALARM/HOLD state machine then raises warning and alarm outputs. The block replaces the single-channel two-flop detector/controller pair and sits between the distance sensor front-end and the motion controller.

Parameters:
- NUM_SENSORS, 4: number of distance channels (>=1).
- DATA_IN_WIDTH, 16: width of each distance sample, unsigned.
- MIN_DIST, 50: channel becomes "near" when distance < MIN_DIST.
- CLEAR_DIST, 60: channel becomes "far" when distance >= CLEAR_DIST. Must be >= MIN_DIST.
- DEBOUNCE, 3: consecutive qualifying samples needed to change a channel's detect bit (>=1).
- ALARM_COUNT, 2: number of simultaneously detected channels that forces ALARM (1..NUM_SENSORS).
- WARN_CYCLES, 8: cycles allowed in WARN before escalating to ALARM (>=1).
- HOLD_CYCLES, 16: cycles the alarm is held after all channels clear (>=1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous reset, active-high.
- dist_v, input, NUM_SENSORS*DATA_IN_WIDTH: packed distances; channel i = dist_v[i*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- obs_detected_out, output, NUM_SENSORS: per-channel debounced detect bit, registered.
- obs_count, output, $clog2(NUM_SENSORS+1): popcount of obs_detected_out, combinational from the registers.
- warn_flag, output, 1: high while state == WARN.
- alarm_flag, output, 1: high while state is ALARM or HOLD.
- state_out, output, 2: SAFE=0, WARN=1, ALARM=2, HOLD=3.

Behaviour:
- Reset (async, rst=1): dist_q=0, all debounce counters=0, obs_detected_out=0, timer=0, state=SAFE. Therefore warn_flag=0, alarm_flag=0, state_out=0, obs_count=0. Reset asserted mid-operation aborts immediately to these values; nothing is retained.
- Input stage: dist_v is registered into dist_q every cycle, adding one cycle of latency.
- Per channel, using dist_q[i]:
  - near = dist_q[i] < MIN_DIST; far = dist_q[i] >= CLEAR_DIST.
  - Values in [MIN_DIST, CLEAR_DIST) are neither near nor far.
- Debounce, per channel:
  - When obs=0, the qualifying condition is near; when obs=1, it is far.
  - Condition true and cnt == DEBOUNCE-1: toggle obs, cnt <= 0.
  - Condition true otherwise: cnt++.
  - Condition false: cnt <= 0. This includes dwelling in the hysteresis band.
  - Latency: dist_v held near from before edge 0 makes obs rise after edge DEBOUNCE. Clearing is symmetric.
- FSM, evaluated on registered obs bits; n = obs_count:
  - SAFE: if n >= ALARM_COUNT go to ALARM; else if n >= 1 go to WARN and load timer.
  - WARN: n == 0 goes to SAFE. n >= ALARM_COUNT goes to ALARM. Otherwise, once WARN has been occupied for WARN_CYCLES cycles, go to ALARM.
  - ALARM: n == 0 goes to HOLD and loads the timer with HOLD_CYCLES; otherwise stay.
  - HOLD: n >= 1 goes back to ALARM. Otherwise HOLD is visible for exactly HOLD_CYCLES cycles, then SAFE.
- Simultaneous events: the ALARM_COUNT check has priority over the WARN timer expiry. A re-detection in HOLD has priority over HOLD expiry.
- Timer width: $clog2(max(WARN_CYCLES, HOLD_CYCLES)+1). It is reloaded on every state entry, so it never wraps.
- All outputs except obs_count come directly from flops.
- Comparisons are unsigned. The full input range is legal, including 0 and all-ones.

Optional Feature:
- Macro: ROBOT_ALARM_ACK_EN.
- When defined:
  - Adds input port alarm_ack (1 bit).
  - When the HOLD timer expires, the FSM stays in HOLD with timer=0 (alarm_flag stays high) until a cycle with alarm_ack=1 and n==0, then goes to SAFE.
  - alarm_ack is ignored in SAFE, WARN and ALARM.
  - alarm_ack during the hold countdown does not shorten it.
  - Re-detection in the latched HOLD returns to ALARM.
- When undefined: no alarm_ack port; HOLD auto-returns to SAFE as specified above.

Test Plan:
1. Reset with dist_v all 1000 -> all outputs 0; hold 20 cycles -> state_out stays 0.
2. Channel 0 = 30, others 1000, held -> obs_detected_out=4'b0001 after edge 3, state WARN next edge, ALARM 8 cycles later. Then set ch0=1000 -> obs clears after 3 edges, HOLD for 16 cycles, then SAFE.
3. Channel 1 toggles 30/1000 every 2 cycles -> obs never sets, state stays SAFE. Channel 1 held at 55 after detection -> stays detected (hysteresis band).
4. Channels 0 and 2 = 10 simultaneously -> obs_count=2, SAFE goes directly to ALARM, skipping WARN.
5. In HOLD at cycle 5, channel 3 = 20 for 3+ samples -> returns to ALARM, timer reloads on the next clear.
6. With ROBOT_ALARM_ACK_EN: HOLD expires -> alarm_flag stays 1; pulse alarm_ack -> SAFE next edge. Reset asserted mid-ALARM -> all outputs 0 immediately.
